// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [DEPTH-1:0]     busy_vec
);

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic [AW-1:0]     wa [NUM_WR];
  logic [DW-1:0]     wd [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic [AW-1:0]     ra [NUM_RD];
  logic              iss_ok;

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j]    = wr_addr[j*AW +: AW];
      wd[j]    = wr_data[j*DW +: DW];
      wr_ok[j] = wr_en[j] &&
                 !((ZERO_REG != 0) && (wa[j] == '0));
    end
    for (int k = 0; k < NUM_RD; k++) begin
      ra[k] = rd_addr[k*AW +: AW];
    end
    iss_ok = iss_en &&
             !((ZERO_REG != 0) && (iss_addr == '0));
  end

  // Clears first, then the set, so a new issue beats a retiring write.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_d[wa[j]] = 1'b0;
    end
    if (iss_ok) busy_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) regs_q[wa[j]] <= wd[j];
      end
    end
  end

  assign busy_vec = busy_q;

`ifdef RF_BYPASS_EN
  logic [NUM_RD-1:0] hit;
`endif

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
`ifdef RF_BYPASS_EN
    hit = '0;
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DW +: DW] = regs_q[ra[k]];
      rd_busy[k]          = busy_q[ra[k]];
`ifdef RF_BYPASS_EN
      // Writes are dropped while reset is held, so nothing to forward.
      for (int j = 0; j < NUM_WR; j++) begin
        if (!reset && wr_ok[j] && (wa[j] == ra[k])) begin
          rd_data[k*DW +: DW] = wd[j];
          hit[k]              = 1'b1;
        end
      end
      if (hit[k] && !(iss_ok && (iss_addr == ra[k]))) begin
        rd_busy[k] = 1'b0;
      end
`endif
      if ((ZERO_REG != 0) && (ra[k] == '0)) begin
        rd_data[k*DW +: DW] = '0;
        rd_busy[k]          = 1'b0;
      end
    end
  end

endmodule
